// File: rtl/otter_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// otter_muldiv_unit_pkg
//   Shared definitions for the OTTER RV32M multiply/divide unit.
//   - XLEN / MD_ITER : operand width and the iteration count (one bit per edge)
//   - muldiv_op_t    : RV32M funct3 encodings
//   - md_state_t     : controller states, with legacy-style ST_* constants
//   - cond_neg()     : two's-complement negate when a sign flag is set
// ---------------------------------------------------------------------------
package otter_muldiv_unit_pkg;

   localparam int XLEN    = 32;
   localparam int MD_ITER = XLEN;
   localparam int CNT_W   = $clog2(MD_ITER);

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } md_state_t;

   // Plain vector encodings of the states, for code that keeps state in logic.
   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_CALC   = CALC;
   localparam logic [1:0] ST_FINISH = FINISH;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                input logic            neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/otter_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// otter_muldiv_unit_if
//   Request/response bundle between the OTTER control path and the mul/div
//   unit.
//   master : drives md_start, md_funct3, md_src_a, md_src_b
//            observes md_ready, md_busy, md_done, md_result
//   slave  : the unit itself (mirror image of master)
// ---------------------------------------------------------------------------
interface otter_muldiv_unit_if;
   import otter_muldiv_unit_pkg::*;

   logic            md_start;
   logic [2:0]      md_funct3;
   logic [XLEN-1:0] md_src_a;
   logic [XLEN-1:0] md_src_b;
   logic            md_ready;
   logic            md_busy;
   logic            md_done;
   logic [XLEN-1:0] md_result;

   modport master (
      output md_start, md_funct3, md_src_a, md_src_b,
      input  md_ready, md_busy, md_done, md_result
   );

   modport slave (
      input  md_start, md_funct3, md_src_a, md_src_b,
      output md_ready, md_busy, md_done, md_result
   );

endinterface

// File: rtl/otter_muldiv_unit.sv
// ---------------------------------------------------------------------------
// otter_muldiv_unit
//   Iterative RV32M multiply/divide unit. A start pulse in IDLE latches the
//   operation and operands; 32 shift-add (multiply) or restoring-divide
//   iterations follow, then a FINISH cycle applies sign correction and special
//   cases and pulses md_done with the registered result. Fixed latency: 33
//   edges from the accepting edge to the edge that raises md_done.
//
//   Ports
//     clk   : system clock, rising edge
//     rst   : synchronous active-high reset
//     md    : otter_muldiv_unit_if.slave
//             md_start/md_funct3/md_src_a/md_src_b in,
//             md_ready/md_busy/md_done/md_result out
// ---------------------------------------------------------------------------
module otter_muldiv_unit
   import otter_muldiv_unit_pkg::*;
(
   input logic                clk,
   input logic                rst,
   otter_muldiv_unit_if.slave md
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MD_ITER - 1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   // ---------------- control state ----------------
   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  result_q;
   logic             done_q;

   // ---------------- datapath registers ----------------
   // Multiply: acc = {0, high product, low product / remaining multiplier}.
   // Divide:   acc = {remainder (XLEN+1), quotient / remaining dividend}.
   muldiv_op_t      op_q;
   logic [2*XLEN:0] acc;
   logic [XLEN-1:0] opnd_b;      // |multiplicand| or |divisor|
   logic [XLEN-1:0] dividend_q;  // raw rs1, returned as remainder on /0
   logic            neg_q;       // product or quotient must be negated
   logic            neg_r_q;     // remainder must be negated (dividend sign)
   logic            div0_q;
   logic            ovf_q;

   // ---------------- request decode ----------------
   muldiv_op_t op_in;
   logic       a_signed;
   logic       b_signed;
   logic       sign_a;
   logic       sign_b;
   logic       div0_in;
   logic       ovf_in;
   logic       accept;

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      op_in    = muldiv_op_t'(md.md_funct3);
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op_in)
         OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default:   ;
      endcase
   end

   assign sign_a  = a_signed & md.md_src_a[XLEN-1];
   assign sign_b  = b_signed & md.md_src_b[XLEN-1];
   assign div0_in = (md.md_src_b == '0);
   // Only signed divide/remainder can overflow; MULH is also signed*signed,
   // hence the explicit divide check on funct3[2].
   assign ovf_in  = op_in[2] & a_signed & b_signed &
                    (md.md_src_a == INT_MIN) & (md.md_src_b == '1);
   assign accept  = (state == ST_IDLE) & md.md_start;

   // ---------------- shared iteration adder ----------------
   // One XLEN+1 wide add/subtract. For divide the carry out of the widened
   // sum is the "no borrow" flag, i.e. the trial subtraction was non-negative.
   logic            is_div;
   logic [XLEN:0]   add_a;
   logic [XLEN:0]   add_b;
   logic [XLEN+1:0] add_sum;
   logic            keep;
   logic [2*XLEN:0] acc_next;

   assign is_div = op_q[2];

   always_comb begin
      add_a    = is_div ? acc[2*XLEN-1:XLEN-1] : acc[2*XLEN:XLEN];
      add_b    = (is_div | acc[0]) ? {1'b0, opnd_b} : '0;
      add_sum  = {1'b0, add_a} + {1'b0, (is_div ? ~add_b : add_b)}
               + {{(XLEN+1){1'b0}}, is_div};
      keep     = add_sum[XLEN+1];
      acc_next = acc;
      if (is_div) begin
         // remainder:quotient shifted left one, quotient LSB = trial success
         acc_next = {(keep ? add_sum[XLEN:0] : add_a), acc[XLEN-2:0], keep};
      end else begin
         // {carry, upper + multiplicand, lower} shifted right one
         acc_next = {1'b0, add_sum[XLEN:0], acc[XLEN-1:1]};
      end
   end

   // ---------------- result selection ----------------
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   quot_s;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   final_result;

   always_comb begin
      // Negating the full double-width product keeps the high half correct.
      product      = neg_q ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
      quot_s       = cond_neg(acc[XLEN-1:0], neg_q);
      rem_s        = cond_neg(acc[2*XLEN-1:XLEN], neg_r_q);
      final_result = product[XLEN-1:0];
      case (op_q)
         OP_MUL:                       final_result = product[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_result = product[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU: begin
            if (div0_q)     final_result = '1;
            else if (ovf_q) final_result = INT_MIN;
            else            final_result = quot_s;
         end
         OP_REM, OP_REMU: begin
            if (div0_q)     final_result = dividend_q;
            else if (ovf_q) final_result = '0;
            else            final_result = rem_s;
         end
         default:           final_result = product[XLEN-1:0];
      endcase
   end

   // ---------------- controller ----------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (md.md_start) begin
                  count <= '0;
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (count == LAST_CNT) begin
                  state <= ST_FINISH;
               end else begin
                  count <= count + 1'b1;
               end
            end
            ST_FINISH: begin
               result_q <= final_result;
               done_q   <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---------------- datapath ----------------
   // NOTE: the datapath registers carry no reset; they are fully reloaded on
   // every accepted request and are never observed before that.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q       <= op_in;
         acc        <= {{(XLEN+1){1'b0}}, cond_neg(md.md_src_a, sign_a)};
         opnd_b     <= cond_neg(md.md_src_b, sign_b);
         dividend_q <= md.md_src_a;
         neg_q      <= sign_a ^ sign_b;
         neg_r_q    <= sign_a;
         div0_q     <= div0_in;
         ovf_q      <= ovf_in;
      end else if (state == ST_CALC) begin
         acc <= acc_next;
      end
   end

   // ---------------- outputs ----------------
   assign md.md_ready  = (state == ST_IDLE);
   assign md.md_busy   = (state != ST_IDLE);
   assign md.md_done   = done_q;
   assign md.md_result = result_q;

endmodule

// File: tb/tb_otter_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_otter_muldiv_unit
//   Scoreboard bench for otter_muldiv_unit: expected results are queued when
//   a request is driven and compared when md_done is seen.
// ---------------------------------------------------------------------------
module tb_otter_muldiv_unit;
   import otter_muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   otter_muldiv_unit_if md_if();

   otter_muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .md  (md_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];
   logic [31:0] last_exp = '0;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard side: every done pulse must match the oldest queued entry.
   always @(negedge clk) begin
      if (md_if.md_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            string t;
            t        = tag_q.pop_front();
            last_exp = exp_q.pop_front();
            check(t, md_if.md_result, last_exp);
         end
      end
   end

   // Independent reference for the RV32M operations.
   function automatic logic [31:0] model(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] sa;
      logic [63:0] sb;
      logic        ovf;
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = ua * ub; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Drive a request at the current negedge; the next posedge is E0.
   task automatic start_op(input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp,
                           input string tag);
      md_if.md_start  = 1'b1;
      md_if.md_funct3 = f;
      md_if.md_src_a  = a;
      md_if.md_src_b  = b;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   // Wait (bounded) for md_done. lat counts negedges after the request was
   // driven; busy_n counts cycles with md_busy high. glitch_at > 0 pulses a
   // stray start with junk operands at that cycle.
   task automatic wait_done(input int glitch_at, output int lat,
                            output int busy_n);
      lat    = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            md_if.md_start  = 1'b0;
            md_if.md_src_a  = $urandom;
            md_if.md_src_b  = $urandom;
            md_if.md_funct3 = 3'($urandom_range(0, 7));
         end
         if (md_if.md_busy === 1'b1) busy_n++;
         if (glitch_at > 0 && lat == glitch_at) begin
            check("ready_low_while_busy", {31'b0, md_if.md_ready}, 32'd0);
            md_if.md_start  = 1'b1;
            md_if.md_funct3 = 3'd0;
            md_if.md_src_a  = 32'd1000;
            md_if.md_src_b  = 32'd3;
         end
         if (glitch_at > 0 && lat == glitch_at + 1) md_if.md_start = 1'b0;
      end while (md_if.md_done !== 1'b1 && lat < 60);
      if (md_if.md_done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
   endtask

   // One complete operation including latency and busy-length checks.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input string tag);
      int lat;
      int busy_n;
      @(negedge clk);
      start_op(f, a, b, exp, tag);
      wait_done(0, lat, busy_n);
      check({tag, "_latency"}, 32'(lat), 32'd34);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
   endtask

   initial begin
      int lat;
      int busy_n;
      rst             = 1'b1;
      md_if.md_start  = 1'b0;
      md_if.md_funct3 = 3'd0;
      md_if.md_src_a  = '0;
      md_if.md_src_b  = '0;
      repeat (3) @(negedge clk);
      check("reset_ready",  {31'b0, md_if.md_ready}, 32'd1);
      check("reset_busy",   {31'b0, md_if.md_busy},  32'd0);
      check("reset_done",   {31'b0, md_if.md_done},  32'd0);
      check("reset_result", md_if.md_result,         32'd0);
      rst = 1'b0;

      // 1. basic multiply, latency and busy window
      run_op(3'd0, 32'd7, 32'd6, 32'd42, "mul_7x6");
      @(negedge clk);
      check("result_held", md_if.md_result, last_exp);
      check("done_one_cycle", {31'b0, md_if.md_done}, 32'd0);

      // 2. multiply-high forms
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");

      // 3. divide forms
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
      run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
      run_op(3'd7, 32'd100, 32'd7, 32'd2,  "remu_100_7");

      // 4. special cases, still fixed latency
      run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
      run_op(3'd7, 32'd5, 32'd0, 32'd5,         "remu_by_zero");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_by_zero");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_overflow");

      // 5a. stray start while busy is ignored
      @(negedge clk);
      start_op(3'd0, 32'd7, 32'd6, 32'd42, "mul_with_stray_start");
      wait_done(10, lat, busy_n);
      check("stray_latency", 32'(lat), 32'd34);
      repeat (40) @(negedge clk);
      check("stray_not_queued_busy", {31'b0, md_if.md_busy}, 32'd0);

      // 5b. back-to-back: new start in the done cycle
      @(negedge clk);
      start_op(3'd5, 32'd100, 32'd7, 32'd14, "b2b_first");
      wait_done(0, lat, busy_n);
      start_op(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, "b2b_second");
      wait_done(0, lat, busy_n);
      check("b2b_second_latency", 32'(lat), 32'd34);

      // 6. reset mid-operation: no done, outputs cleared
      @(negedge clk);
      md_if.md_start  = 1'b1;
      md_if.md_funct3 = 3'd0;
      md_if.md_src_a  = 32'h1234;
      md_if.md_src_b  = 32'h5678;
      @(negedge clk);
      md_if.md_start = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy",   {31'b0, md_if.md_busy},  32'd0);
      check("midrst_ready",  {31'b0, md_if.md_ready}, 32'd1);
      check("midrst_result", md_if.md_result,         32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      run_op(3'd0, 32'd3, 32'd5, 32'd15, "mul_after_reset");

      // random sweep across every funct3
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic [2:0]  f;
         f = 3'(i);
         a = $urandom;
         b = (i >= 4) ? 32'($urandom_range(1, 5000)) : $urandom;
         if (i == 6) a = -32'd98765;
         run_op(f, a, b, model(f, a, b), $sformatf("rand_f%0d", i));
      end

      @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
